// File: rtl/id_control_path.sv
// ID-stage control path: PC+4 adder, instruction decode with bubble mux,
// and the ID/EX control latch feeding the execute stage.
module id_control_path (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_current,
    output logic [31:0] pc_plus_4,
    input  logic [31:0] instruction,
    input  logic        mux_select,
    output logic        reg_write_enable,
    output logic        mem_write_enable,
    output logic        mem_to_reg_select,
    output logic        alu_source_select,
    output logic        status_bit,
    output logic [1:0]  alu_operation,
    output logic        pc_source_select,
    output logic        ex_reg_write_enable,
    output logic        ex_mem_write_enable,
    output logic        ex_mem_to_reg_select,
    output logic        ex_alu_source_select,
    output logic [1:0]  ex_alu_operation
);

    logic       decRegWrite;
    logic       decMemWrite;
    logic       decMemToReg;
    logic       decAluSrc;
    logic       decStatus;
    logic [1:0] decAluOp;
    logic       decPcSrc;

    logic       exRegWrite_q, exRegWrite_d;
    logic       exMemWrite_q, exMemWrite_d;
    logic       exMemToReg_q, exMemToReg_d;
    logic       exAluSrc_q,   exAluSrc_d;
    logic [1:0] exAluOp_q,    exAluOp_d;

    assign pc_plus_4 = pc_current + 32'd4;

    always_comb begin
        decRegWrite = 1'b0;
        decMemWrite = 1'b0;
        decMemToReg = 1'b0;
        decAluSrc   = 1'b0;
        decStatus   = 1'b0;
        decAluOp    = 2'b00;
        decPcSrc    = 1'b0;
        // The all-zero word and the unconditional (cond = 1111) space are NOPs.
        if ((instruction != 32'd0) && (instruction[31:28] != 4'hF)) begin
            case (instruction[27:26])
                2'b00: begin
                    case (instruction[24:21])
                        4'b0000, 4'b0010, 4'b0100, 4'b1100: begin
                            decRegWrite = 1'b1;
                            decAluSrc   = instruction[25];
                            decStatus   = instruction[20];
                            case (instruction[24:21])
                                4'b0000: decAluOp = 2'b10;
                                4'b0010: decAluOp = 2'b01;
                                4'b0100: decAluOp = 2'b00;
                                default: decAluOp = 2'b11;
                            endcase
                        end
                        4'b1010: begin
                            decAluSrc = instruction[25];
                            decStatus = 1'b1;
                            decAluOp  = 2'b01;
                        end
                        default: ;
                    endcase
                end
                2'b01: begin
                    // I = 0 selects the 12-bit immediate offset; U chooses add or subtract.
                    decAluSrc = ~instruction[25];
                    decAluOp  = instruction[23] ? 2'b00 : 2'b01;
                    if (instruction[20]) begin
                        decRegWrite = 1'b1;
                        decMemToReg = 1'b1;
                    end else begin
                        decMemWrite = 1'b1;
                    end
                end
                2'b10: begin
                    if (instruction[25]) begin
                        decPcSrc    = 1'b1;
                        decAluSrc   = 1'b1;
                        decRegWrite = instruction[24];
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        reg_write_enable  = 1'b0;
        mem_write_enable  = 1'b0;
        mem_to_reg_select = 1'b0;
        alu_source_select = 1'b0;
        status_bit        = 1'b0;
        alu_operation     = 2'b00;
        pc_source_select  = 1'b0;
        if (!mux_select) begin
            reg_write_enable  = decRegWrite;
            mem_write_enable  = decMemWrite;
            mem_to_reg_select = decMemToReg;
            alu_source_select = decAluSrc;
            status_bit        = decStatus;
            alu_operation     = decAluOp;
            pc_source_select  = decPcSrc;
        end
    end

    assign exRegWrite_d = reg_write_enable;
    assign exMemWrite_d = mem_write_enable;
    assign exMemToReg_d = mem_to_reg_select;
    assign exAluSrc_d   = alu_source_select;
    assign exAluOp_d    = alu_operation;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            exRegWrite_q <= 1'b0;
            exMemWrite_q <= 1'b0;
            exMemToReg_q <= 1'b0;
            exAluSrc_q   <= 1'b0;
            exAluOp_q    <= 2'b00;
        end else begin
            exRegWrite_q <= exRegWrite_d;
            exMemWrite_q <= exMemWrite_d;
            exMemToReg_q <= exMemToReg_d;
            exAluSrc_q   <= exAluSrc_d;
            exAluOp_q    <= exAluOp_d;
        end
    end

    assign ex_reg_write_enable  = exRegWrite_q;
    assign ex_mem_write_enable  = exMemWrite_q;
    assign ex_mem_to_reg_select = exMemToReg_q;
    assign ex_alu_source_select = exAluSrc_q;
    assign ex_alu_operation     = exAluOp_q;

endmodule

// File: tb/tb_id_control_path.sv
// Testbench for id_control_path: directed ARM encodings with literal expectations,
// then randomized instructions checked every cycle against a decode model.
module tb_id_control_path;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pc_current = 32'd0;
    logic [31:0] instruction = 32'd0;
    logic        mux_select = 1'b0;
    logic [31:0] pc_plus_4;
    logic        reg_write_enable, mem_write_enable, mem_to_reg_select;
    logic        alu_source_select, status_bit, pc_source_select;
    logic [1:0]  alu_operation;
    logic        ex_reg_write_enable, ex_mem_write_enable, ex_mem_to_reg_select;
    logic        ex_alu_source_select;
    logic [1:0]  ex_alu_operation;

    int vectors = 0;
    int miscompares = 0;
    bit cmpEn = 1'b0;
    logic [5:0] expEx = 6'd0;

    id_control_path dut (
        .clk(clk), .reset(reset), .pc_current(pc_current), .pc_plus_4(pc_plus_4),
        .instruction(instruction), .mux_select(mux_select),
        .reg_write_enable(reg_write_enable), .mem_write_enable(mem_write_enable),
        .mem_to_reg_select(mem_to_reg_select), .alu_source_select(alu_source_select),
        .status_bit(status_bit), .alu_operation(alu_operation),
        .pc_source_select(pc_source_select),
        .ex_reg_write_enable(ex_reg_write_enable), .ex_mem_write_enable(ex_mem_write_enable),
        .ex_mem_to_reg_select(ex_mem_to_reg_select),
        .ex_alu_source_select(ex_alu_source_select), .ex_alu_operation(ex_alu_operation)
    );

    always #5 clk = ~clk;

    // Packed views: {pcsrc, aluop[1:0], status, alusrc, memtoreg, memwrite, regwrite}
    // and {aluop[1:0], alusrc, memtoreg, memwrite, regwrite}.
    wire [7:0] dutCtrl = {pc_source_select, alu_operation, status_bit, alu_source_select,
                          mem_to_reg_select, mem_write_enable, reg_write_enable};
    wire [5:0] dutEx   = {ex_alu_operation, ex_alu_source_select, ex_mem_to_reg_select,
                          ex_mem_write_enable, ex_reg_write_enable};

    function automatic logic [7:0] refDecode(input logic [31:0] ins);
        bit pcs = 0, s = 0, src = 0, m2r = 0, mw = 0, rw = 0;
        logic [1:0] op = 2'b00;
        logic [3:0] opc = ins[24:21];
        if (ins == 32'd0 || ins[31:28] == 4'hF) return 8'd0;
        if (ins[27:26] == 2'b00) begin
            if (opc == 4'd0 || opc == 4'd2 || opc == 4'd4 || opc == 4'd12) begin
                rw = 1; s = ins[20]; src = ins[25];
                op = (opc == 4'd0) ? 2'b10 : (opc == 4'd2) ? 2'b01 : (opc == 4'd4) ? 2'b00 : 2'b11;
            end else if (opc == 4'd10) begin
                s = 1; src = ins[25]; op = 2'b01;
            end
        end else if (ins[27:26] == 2'b01) begin
            src = !ins[25];
            op  = ins[23] ? 2'b00 : 2'b01;
            if (ins[20]) begin rw = 1; m2r = 1; end
            else mw = 1;
        end else if (ins[27:25] == 3'b101) begin
            pcs = 1; src = 1; rw = ins[24];
        end
        return {pcs, op, s, src, m2r, mw, rw};
    endfunction

    function automatic logic [7:0] refMuxed(input logic [31:0] ins, input logic bubble);
        return bubble ? 8'd0 : refDecode(ins);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] ins, input logic bubble, input logic [31:0] pc);
        @(posedge clk);
        #2;
        instruction = ins;
        mux_select  = bubble;
        pc_current  = pc;
    endtask

    // Model of the ID/EX latch: captures the expected muxed control each edge.
    always @(posedge clk or negedge reset) begin
        if (!reset) expEx = 6'd0;
        else begin
            logic [7:0] c;
            c = refMuxed(instruction, mux_select);
            expEx = {c[6:5], c[3:0]};
        end
    end

    always @(negedge clk) begin
        if (cmpEn) begin
            checkOutput("pc_plus_4", pc_plus_4, pc_current + 32'd4);
            checkOutput("ctrl", {24'd0, dutCtrl}, {24'd0, refMuxed(instruction, mux_select)});
            checkOutput("ex_ctrl", {26'd0, dutEx}, {26'd0, expEx});
        end
    end

    typedef struct {
        logic [31:0] ins;
        logic [7:0]  ctrl;
        string       name;
    } vec_t;

    vec_t directed[7];

    initial begin
        directed[0] = '{32'hE2110000, 8'h59, "ANDS_imm"};
        directed[1] = '{32'hE0805183, 8'h01, "ADD_reg"};
        directed[2] = '{32'h00000000, 8'h00, "NOP"};
        directed[3] = '{32'hE7D12000, 8'h05, "LDRB_reg"};
        directed[4] = '{32'hE58A5000, 8'h0A, "STR_imm"};
        directed[5] = '{32'h1AFFFFFD, 8'h88, "BNE"};
        directed[6] = '{32'hDB000009, 8'h89, "BLLE"};

        #1 reset = 1'b0;
        #2;
        checkOutput("reset_ex", {26'd0, dutEx}, 32'd0);
        cmpEn = 1'b1;
        applyStimulus(32'hE2110000, 1'b0, 32'd0);
        applyStimulus(32'hE2110000, 1'b0, 32'd0);
        #1 checkOutput("ex_held_in_reset", {26'd0, dutEx}, 32'd0);
        reset = 1'b1;

        applyStimulus(32'd0, 1'b0, 32'h00000000);
        #1 checkOutput("pc_zero", pc_plus_4, 32'h00000004);
        applyStimulus(32'd0, 1'b0, 32'hFFFFFFFC);
        #1 checkOutput("pc_wrap", pc_plus_4, 32'h00000000);

        foreach (directed[i]) begin
            applyStimulus(directed[i].ins, 1'b0, 32'h100 + 32'(i) * 4);
            #1 checkOutput(directed[i].name, {24'd0, dutCtrl}, {24'd0, directed[i].ctrl});
        end

        applyStimulus(32'hE2110000, 1'b1, 32'h200);
        #1 checkOutput("bubble_ctrl", {24'd0, dutCtrl}, 32'd0);
        applyStimulus(32'hE2110000, 1'b0, 32'h204);
        #1 checkOutput("bubble_ex", {26'd0, dutEx}, 32'd0);
        applyStimulus(32'hE0805183, 1'b0, 32'h208);
        #1 checkOutput("pipe_ands", {30'd0, ex_alu_operation}, 32'd2);
        applyStimulus(32'hE0805183, 1'b0, 32'h20C);
        #1 checkOutput("pipe_add", {30'd0, ex_alu_operation}, 32'd0);

        applyStimulus(32'hE2110000, 1'b0, 32'h210);
        @(posedge clk);
        #3 reset = 1'b0;
        #1 checkOutput("async_reset", {26'd0, dutEx}, 32'd0);
        applyStimulus(32'hE2110000, 1'b0, 32'h214);
        reset = 1'b1;

        for (int n = 0; n < 600; n++) begin
            logic [31:0] ins;
            int k;
            ins = $urandom;
            k = $urandom_range(0, 9);
            if (k == 0) ins = 32'd0;
            else if (k == 1) ins[31:28] = 4'hF;
            else if (k <= 4) begin
                logic [3:0] pick [5] = '{4'd0, 4'd2, 4'd4, 4'd12, 4'd10};
                ins[27:26] = 2'b00;
                ins[24:21] = pick[$urandom_range(0, 4)];
                if (ins[31:28] == 4'hF) ins[31:28] = 4'hE;
            end
            applyStimulus(ins, ($urandom_range(0, 7) == 0), $urandom);
            if ($urandom_range(0, 40) == 0) reset = 1'b0;
            else reset = 1'b1;
        end

        @(posedge clk);
        #3;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/id_control_path.md
# id_control_path

Instruction-decode control path for the 5-stage ARM pipeline. It computes the fetch-stage PC+4, decodes the ID-stage instruction into datapath control signals, and forces those signals to zero when a bubble is requested. It registers the execute-stage subset into an ID/EX control latch. It sits between the IF/ID register and the EX stage.

## Interface
- Parameters: none.
- clk  in  1  pipeline clock; rising-edge active.
- reset  in  1  asynchronous, active-low; clears every registered output.
- pc_current  in  32  current program counter.
- pc_plus_4  out  32  pc_current + 4.
- instruction  in  32  instruction held in IF/ID.
- mux_select  in  1  1 = insert bubble (all control zero).
- reg_write_enable  out  1  muxed: register file write.
- mem_write_enable  out  1  muxed: data memory write.
- mem_to_reg_select  out  1  muxed: 1 = writeback from memory.
- alu_source_select  out  1  muxed: 1 = immediate/offset operand.
- status_bit  out  1  muxed: update NZCV flags.
- alu_operation  out  2  muxed: 00 ADD, 01 SUB, 10 AND, 11 ORR.
- pc_source_select  out  1  muxed: 1 = branch target.
- ex_reg_write_enable  out  1  registered copy for EX.
- ex_mem_write_enable  out  1  registered copy for EX.
- ex_mem_to_reg_select  out  1  registered copy for EX.
- ex_alu_source_select  out  1  registered copy for EX.
- ex_alu_operation  out  2  registered copy for EX.

## Operation
- Adder: pc_plus_4 = pc_current + 4, modulo 2^32. It has no carry-out.
- The condition field [31:28] is not evaluated here. Exception: cond = 1111 decodes as NOP.
- Instruction 0x00000000 is the NOP and decodes as all control zero.
- Data processing ([27:26]=00):
  - alu_source_select = bit 25.
  - status_bit = bit 20.
  - Opcode [24:21] AND→10, SUB→01, ADD→00, ORR→11, each with reg_write = 1.
  - CMP (1010) gives op 01, reg_write = 0, status = 1.
  - Any other opcode decodes as all zero.
- Load/store ([27:26]=01):
  - alu_source_select = ~bit 25 (immediate offset when I = 0).
  - alu_operation = 00 if U (bit 23) = 1, else 01.
  - L (bit 20) = 1: reg_write = 1, mem_to_reg = 1.
  - L = 0: mem_write = 1.
  - Byte bit 22 does not affect the control outputs.
- Branch ([27:25]=101):
  - pc_source_select = 1, alu_source_select = 1, alu_operation = 00.
  - reg_write = bit 24 (BL writes the link register).
- Other encodings, [27:26]=11 or 100: all zero.
- Control not listed above is 0.
- Bubble mux: mux_select = 1 forces all seven muxed outputs to 0. mux_select = 0 passes the decode unchanged.

## Timing
- pc_plus_4 and the seven muxed outputs are purely combinational from their inputs, with zero-cycle latency.
- The ex_* outputs are loaded from the muxed signals on every rising clk. Latency is 1 cycle. There is no enable.
- reset low: ex_* go to 0 immediately, without waiting for a clock edge, and hold 0 while reset is low.
- The first capture happens on the first rising edge after reset is released.
- Reset does not affect the combinational outputs.
- mux_select asserted in cycle N gives ex_* = 0 after edge N+1. This is how a bubble is injected into EX.

## Test plan
- pc_current = 0 → pc_plus_4 = 4. pc_current = 0xFFFFFFFC → pc_plus_4 = 0x00000000.
- Data processing:
  - 0xE2110000 (ANDS imm) → RW=1, ALUSrc=1, S=1, op=10, others 0.
  - 0xE0805183 (ADD reg) → RW=1, ALUSrc=0, S=0, op=00.
  - 0x00000000 → all 0.
- Load/store:
  - 0xE7D12000 (LDRB reg offset) → RW=1, MemtoReg=1, ALUSrc=0, op=00, MemWrite=0.
  - 0xE58A5000 (STR imm) → MemWrite=1, ALUSrc=1, RW=0, op=00.
- Branch:
  - 0x1AFFFFFD (BNE) → PCSrc=1, RW=0.
  - 0xDB000009 (BLLE) → PCSrc=1, RW=1.
- Bubble: ANDS with mux_select = 1 → all muxed outputs 0. After the next edge, ex_* = 0.
- Pipeline and reset:
  - ANDS then ADD on consecutive cycles → ex_alu_operation = 10, then 00 one cycle later.
  - Pull reset low mid-cycle → ex_* = 0 before the next edge.
